lamp_seq_gen: RTL and testbench
===============================

# lamp_seq_gen

Lamp-sequence transmitter: plays a programmed sequence of one-hot lamp activations on `lamp1`/`lamp2`/`lamp3`, holding each step for a configurable number of cycles. It is the stimulus side of the lamp-sequence alarm detector. It drives the detector's lamp inputs in the lab top level and in benches, so the detector's 1→2→3 alarm path and its sequence-break paths can be exercised deterministically. A start/busy/done handshake lets a controller launch one-shot or looping playback.

## Interface
- `MAX_STEPS`, default 8: maximum sequence length.
- `HOLD_W`, default 4: width of the per-step hold field.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `abort`  in  1  stop playback; honoured in PLAY.
- `loop`  in  1  sampled at end of last step; 1 restarts from step 0.
- `pattern`  in  2*MAX_STEPS  step codes; step s at bits [2s+1:2s]. Codes: 00 off, 01 lamp1, 10 lamp2, 11 lamp3.
- `length`  in  $clog2(MAX_STEPS+1)  number of steps to play.
- `hold`  in  HOLD_W  each step is shown for hold+1 cycles.
- `lamp1`, `lamp2`, `lamp3`  out  1 each  registered lamp drives; at most one high.
- `busy`  out  1  high in PLAY.
- `done`  out  1  one-cycle pulse on normal completion.
- `step_idx`  out  $clog2(MAX_STEPS)  current step index, 0 outside PLAY.

## Operation
- Reset values:
  - state IDLE.
  - All lamps 0, `busy` 0, `done` 0, `step_idx` 0.
  - Hold counter 0.
- States:
  - IDLE → PLAY when `start`=1 and `length`≠0.
  - PLAY → IDLE on `abort`.
  - PLAY → PLAY (restart) at end of sequence when `loop`=1.
  - PLAY → DONE at end of sequence when `loop`=0.
  - DONE → IDLE unconditionally.
- On the start edge, latch `pattern`, `hold` and the effective length into internal registers. Later input changes do not affect that run.
- Effective length = min(`length`, MAX_STEPS).
- `start` with `length`=0 is ignored: the block stays in IDLE with no outputs asserted.
- `start` is ignored in PLAY and DONE.
- Step timing:
  - The hold counter loads the latched `hold` on entering each step and decrements each cycle.
  - When it reaches 0, the block advances to the next step.
  - After the last step, the block restarts at step 0 (if `loop`=1) or enters DONE.
- Lamp outputs are decoded from the current step code. Code 00 drives all lamps 0.
- Consecutive identical codes keep the lamp continuously high, with no gap.
- `abort` takes priority over step advance and over `loop`.
- On abort: next cycle is IDLE, lamps 0, no `done` pulse.
- DONE lasts one cycle: lamps 0, `busy` 0, `done` 1.
- Reset mid-PLAY returns to reset values on the next edge, with no `done`.

## Timing
- Latency:
  - `start` is high before edge k, in IDLE.
  - From edge k: `busy`=1, step-0 lamp valid, `step_idx`=0.
- Step s is visible for exactly hold+1 cycles.
- Total PLAY duration is L*(hold+1) cycles, where L is the effective length.
- `done` is high for the single cycle after PLAY ends.
- IDLE is re-entered one cycle later. A new `start` is accepted from that IDLE cycle.
- `loop` is sampled in the final cycle of the last step. With `loop`=1, step 0 follows immediately: no DONE cycle and no lamp-off gap.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `lamp_pkg` holds:
  - `lamp_code_t`: enum of 2-bit codes LAMP_OFF, LAMP_1, LAMP_2, LAMP_3. The detector testbench reuses it.
  - `seq_state_t`: states IDLE, PLAY, DONE.
- Sub-module `lamp_hold_timer`:
  - HOLD_W-bit loadable down-counter with `load`, `value` and `expire` ports.
  - `expire` is high when the count is 0.
  - The top level instantiates it once.

## Test plan
- pattern={11,10,01} (steps 0..2 = lamp1, lamp2, lamp3), length=3, hold=0, start at edge 0.
  - Lamps 100, 010, 001 on cycles 1–3; `done` on cycle 4.
  - Detector in loopback raises alarm the cycle after lamp3 is registered.
- Same pattern with hold=2.
  - Each lamp held 3 cycles; `busy` high 9 cycles; `done` at cycle 10.
- loop=1, length=2 (lamp1, lamp2), hold=0.
  - Lamps alternate 100, 010 indefinitely with no off cycle and no `done`.
  - Drop `loop` during step 0, then `done` follows the next lamp2 cycle.
- abort asserted during step 1 of a 3-step run.
  - Next cycle: lamps 000, `busy` 0, no `done`.
  - A `start` pulse one cycle later is accepted.
- Start gating:
  - length=0 with `start`: no `busy`.
  - length=12 with MAX_STEPS=8: plays exactly 8 steps.
  - `start` pulsed mid-run: ignored, and the sequence is unchanged.
- Reset asserted during step 1.
  - Next edge: all outputs 0, IDLE.
  - Subsequent `start` replays from step 0.

Source files
------------

// File: rtl/lamp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lamp_pkg: shared lamp codes and sequencer states                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lamp_pkg;

    typedef enum logic [1:0] {
        LAMP_OFF = 2'b00,
        LAMP_1   = 2'b01,
        LAMP_2   = 2'b10,
        LAMP_3   = 2'b11
    } lamp_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // Returns {lamp3, lamp2, lamp1}.
    function automatic logic [2:0] lamp_onehot(input lamp_code_t code);
        logic [2:0] res;
        res = 3'b000;
        case (code)
            LAMP_1:  res = 3'b001;
            LAMP_2:  res = 3'b010;
            LAMP_3:  res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_seq_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lamp_seq_gen_if: control and lamp-drive bundle of the sequencer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface lamp_seq_gen_if #(
    parameter int MAX_STEPS = 8,
    parameter int HOLD_W    = 4
);
    localparam int LEN_W = $clog2(MAX_STEPS + 1);
    localparam int IDX_W = $clog2(MAX_STEPS);

    logic                   start;
    logic                   abort;
    logic                   loop;
    logic [2*MAX_STEPS-1:0] pattern;
    logic [LEN_W-1:0]       length;
    logic [HOLD_W-1:0]      hold;
    logic                   lamp1;
    logic                   lamp2;
    logic                   lamp3;
    logic                   busy;
    logic                   done;
    logic [IDX_W-1:0]       step_idx;

    modport master (
        output start, abort, loop, pattern, length, hold,
        input  lamp1, lamp2, lamp3, busy, done, step_idx
    );

    modport slave (
        input  start, abort, loop, pattern, length, hold,
        output lamp1, lamp2, lamp3, busy, done, step_idx
    );

endinterface
`default_nettype wire

// File: rtl/lamp_hold_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lamp_hold_timer: loadable down-counter, expire while count is 0  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lamp_hold_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HOLD_W-1:0] value,
    output logic              expire
);
    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - HOLD_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule
`default_nettype wire

// File: rtl/lamp_seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lamp_seq_gen: plays a latched one-hot lamp sequence with hold    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lamp_seq_gen
    import lamp_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int HOLD_W    = 4
) (
    input  logic          clk,
    input  logic          reset,
    lamp_seq_gen_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_STEPS + 1);
    localparam int IDX_W = $clog2(MAX_STEPS);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_STEPS);

    seq_state_t             state, state_d;
    logic [2*MAX_STEPS-1:0] pat_q, pat_src;
    logic [HOLD_W-1:0]      hold_q, load_val;
    logic [LEN_W-1:0]       len_q, len_eff;
    logic [IDX_W-1:0]       step_q, step_d;
    lamp_code_t             code_d;
    logic                   busy_d, done_d, latch, load, expire, last_step;
    logic [2:0]             lamps_q;
    logic                   busy_q, done_q;

    assign len_eff   = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    assign last_step = ((LEN_W'(step_q) + LEN_W'(1)) == len_q);
    // In IDLE the step-0 code must come straight from the inputs being latched.
    assign pat_src   = (state == IDLE) ? bus.pattern : pat_q;

    lamp_hold_timer #(.HOLD_W(HOLD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .value  (load_val),
        .expire (expire)
    );

    always_comb begin
        state_d  = state;
        step_d   = step_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        latch    = 1'b0;
        load     = 1'b0;
        load_val = hold_q;
        code_d   = LAMP_OFF;
        unique case (state)
            IDLE: begin
                if (bus.start && (bus.length != '0)) begin
                    state_d  = PLAY;
                    step_d   = '0;
                    latch    = 1'b1;
                    load     = 1'b1;
                    load_val = bus.hold;
                    busy_d   = 1'b1;
                end
            end
            PLAY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (expire && last_step) begin
                    step_d = '0;
                    if (bus.loop) begin
                        load   = 1'b1;
                        busy_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (expire) begin
                    step_d = step_q + IDX_W'(1);
                    load   = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
        if (busy_d) begin
            code_d = lamp_code_t'(pat_src[{step_d, 1'b0} +: 2]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step_q  <= '0;
            pat_q   <= '0;
            hold_q  <= '0;
            len_q   <= '0;
            lamps_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            step_q  <= step_d;
            lamps_q <= lamp_onehot(code_d);
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (latch) begin
                pat_q  <= bus.pattern;
                hold_q <= bus.hold;
                len_q  <= len_eff;
            end
        end
    end

    assign bus.lamp1    = lamps_q[0];
    assign bus.lamp2    = lamps_q[1];
    assign bus.lamp3    = lamps_q[2];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;

endmodule
`default_nettype wire

// File: tb/tb_lamp_seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lamp_seq_gen: scoreboard bench for the lamp sequencer         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lamp_seq_gen;

    typedef struct packed {
        logic [2:0] lamps;   // {lamp3, lamp2, lamp1}
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic clk;
    logic reset;

    lamp_seq_gen_if #(.MAX_STEPS(8), .HOLD_W(4)) bus ();

    lamp_seq_gen #(.MAX_STEPS(8), .HOLD_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_total;
    int    n_pass;

    exp_t  m_exp;
    exp_t  m_act;
    string m_name;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = {bus.lamp3, bus.lamp2, bus.lamp1, bus.busy, bus.done, bus.step_idx};
            n_total++;
            if (m_act === m_exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t: lamps/busy/done/idx got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         m_name, $time, m_act.lamps, m_act.busy, m_act.done, m_act.idx,
                         m_exp.lamps, m_exp.busy, m_exp.done, m_exp.idx);
            end
        end
    end

    // Expectation for the outputs that follow the next rising edge.
    task automatic tick(input exp_t e, input string nm);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Model: cycle c of a run shows step (c mod L*(hold+1)) / (hold+1).
    task automatic play(input logic [15:0] pat, input int len, input int hld,
                        input int iters, input int stop_at, input bit use_reset,
                        input bit start_mid, input string nm);
        int         l, t, last, step;
        logic [1:0] code;
        exp_t       e;
        l = (len > 8) ? 8 : len;
        bus.start   = 1'b1;
        bus.pattern = pat;
        bus.length  = 4'(len);
        bus.hold    = 4'(hld);
        bus.loop    = 1'($urandom);
        if (l == 0) begin
            tick('0, {nm, ":len0"});
            bus.start = 1'b0;
            tick('0, {nm, ":idle"});
            return;
        end
        t    = l * (hld + 1);
        last = (stop_at >= 0) ? stop_at : iters * t - 1;
        for (int c = 0; c <= last; c++) begin
            step = (c % t) / (hld + 1);
            code = pat[2*step +: 2];
            case (code)
                2'd1:    e.lamps = 3'b001;
                2'd2:    e.lamps = 3'b010;
                2'd3:    e.lamps = 3'b100;
                default: e.lamps = 3'b000;
            endcase
            e.busy = 1'b1;
            e.done = 1'b0;
            e.idx  = 3'(step);
            tick(e, nm);
            bus.start   = start_mid && (c == 1);
            bus.pattern = 16'($urandom);
            bus.hold    = 4'($urandom);
            bus.length  = 4'($urandom_range(1, 15));
            bus.loop    = ((c % t) == t - 1) ? (c / t < iters - 1) : 1'($urandom);
            if (c == stop_at) begin
                if (use_reset) reset = 1'b1;
                else           bus.abort = 1'b1;
            end
        end
        if (stop_at >= 0) begin
            tick('0, {nm, ":stopped"});
            reset     = 1'b0;
            bus.abort = 1'b0;
        end else begin
            e      = '0;
            e.done = 1'b1;
            tick(e, {nm, ":done"});
            tick('0, {nm, ":idle"});
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int len, hld, iters, stop;
        clk         = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.loop    = 1'b0;
        bus.pattern = '0;
        bus.length  = '0;
        bus.hold    = '0;
        n_total     = 0;
        n_pass      = 0;

        tick('0, "reset");
        tick('0, "reset");
        reset = 1'b0;
        tick('0, "idle");

        play(16'h0039, 3, 0, 1, -1, 1'b0, 1'b0, "seq_h0");
        play(16'h0039, 3, 2, 1, -1, 1'b0, 1'b0, "seq_h2");
        play(16'h0009, 2, 0, 4, -1, 1'b0, 1'b0, "loop");
        play(16'h0039, 3, 1, 1,  2, 1'b0, 1'b0, "abort");
        play(16'h0039, 3, 0, 1, -1, 1'b0, 1'b0, "after_abort");
        play(16'h1234, 0, 1, 1, -1, 1'b0, 1'b0, "len0");
        play(16'hE4B1, 12, 0, 1, -1, 1'b0, 1'b0, "len12");
        play(16'h0039, 3, 1, 1, -1, 1'b0, 1'b1, "start_mid");
        play(16'h0039, 3, 1, 1,  2, 1'b1, 1'b0, "reset_mid");
        play(16'h0039, 3, 0, 1, -1, 1'b0, 1'b0, "after_reset");

        for (int r = 0; r < 25; r++) begin
            len   = $urandom_range(0, 10);
            hld   = $urandom_range(0, 3);
            iters = $urandom_range(1, 3);
            stop  = -1;
            if (len != 0 && $urandom_range(0, 3) == 0)
                stop = $urandom_range(0, ((len > 8) ? 8 : len) * (hld + 1) * iters - 1);
            play(16'($urandom), len, hld, iters, stop, 1'($urandom), 1'($urandom), "random");
        end

        tick('0, "tail");
        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending %0d expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
